// File: rtl/stw_sched_pkg.sv
// Shared types and constants for the STW test scheduler: FSM states,
// vector count and the broadcast test-pattern table.
package stw_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    ARM,
    WAIT,
    EVAL,
    NEXT,
    FIN
  } stw_state_e;

  localparam int unsigned NUM_VEC   = 2;
  localparam int unsigned VEC_IDX_W = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
  localparam int unsigned PAT_W     = 16;

  typedef struct packed {
    logic [PAT_W-1:0] op1;
    logic [PAT_W-1:0] op2;
    logic [PAT_W-1:0] add;
    logic [PAT_W-1:0] exp;
  } stw_vec_t;

  // Pattern table: exp = op1*op2 + add, truncated to PAT_W bits.
  function automatic stw_vec_t stw_pattern(input logic [VEC_IDX_W-1:0] idx);
    stw_vec_t v;
    v = '{op1: 16'd3, op2: 16'd5, add: 16'd7, exp: 16'd22};
    if (idx == VEC_IDX_W'(1)) begin
      v = '{op1: 16'hFFFE, op2: 16'h0100, add: 16'h0010, exp: 16'hFE10};
    end
    return v;
  endfunction

endpackage

// File: rtl/stw_watchdog.sv
// Loadable down-counter watchdog. Load arms it with TIMEOUT; each enabled
// cycle counts down; expire_o flags the TIMEOUT-th enabled cycle after load.
module stw_watchdog #(
  parameter int unsigned TIMEOUT = 32
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear beats load beats decrement; saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = CNT_W'(TIMEOUT);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && !load_i && (cnt_q <= CNT_W'(1));

endmodule

// File: rtl/stw_test_scheduler.sv
// Self-test-while-working scheduler: walks every PE through each pattern
// vector via the load/start/complete handshake and records a sticky fault map.
module stw_test_scheduler
  import stw_sched_pkg::*;
#(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned NUM_PE    = 16,
  parameter int unsigned TIMEOUT   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 test_req,
  input  logic                 array_idle,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout_err,
  output logic [NUM_PE-1:0]    fault_map,
  output logic [NUM_PE-1:0]    STW_test_load_en,
  output logic [WORD_SIZE-1:0] STW_mult_op1,
  output logic [WORD_SIZE-1:0] STW_mult_op2,
  output logic [WORD_SIZE-1:0] STW_add_op,
  output logic [WORD_SIZE-1:0] STW_expected,
  output logic [NUM_PE-1:0]    STW_start,
  input  logic [NUM_PE-1:0]    STW_complete,
  input  logic [NUM_PE-1:0]    STW_result_out
);

  localparam int unsigned PE_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  stw_state_e             state_q;
  logic [PE_W-1:0]        pe_q;
  logic [VEC_IDX_W-1:0]   vec_q;
  logic                   pass_q;
  logic                   tmo_q;
  logic                   busy_q, done_q, terr_q;
  logic [NUM_PE-1:0]      fmap_q, load_q, start_q;
  logic [WORD_SIZE-1:0]   op1_q, op2_q, add_q, exp_q;

  logic                   more_vec;
  logic [VEC_IDX_W-1:0]   vec_nxt;
  stw_vec_t               pat_nxt;
  logic                   wd_clear, wd_load, wd_en, wd_expire;

  function automatic logic [NUM_PE-1:0] pe_onehot(input logic [PE_W-1:0] idx);
    logic [NUM_PE-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Vector for the next LOAD: advance within a passing PE, else restart at 0.
  always_comb begin
    more_vec = pass_q && (vec_q != VEC_IDX_W'(NUM_VEC - 1));
    vec_nxt  = '0;
    if ((state_q == NEXT) && more_vec) begin
      vec_nxt = vec_q + VEC_IDX_W'(1);
    end
    pat_nxt = stw_pattern(vec_nxt);
  end

  // Watchdog rearms on entry to START and on entry to ARM.
  always_comb begin
    wd_clear = (state_q == IDLE);
    wd_load  = (state_q == LOAD) || ((state_q == START) && STW_complete[pe_q]);
    wd_en    = (state_q == START) || (state_q == ARM) || (state_q == WAIT);
  end

  stw_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wd (
    .clk_i   (clk),
    .rst_i   (rst),
    .clear_i (wd_clear),
    .load_i  (wd_load),
    .en_i    (wd_en),
    .expire_o(wd_expire)
  );

  // Campaign FSM; strobes and operands are registered so they align with
  // the LOAD (load_en) and ARM (start) states.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pe_q    <= '0;
      vec_q   <= '0;
      pass_q  <= 1'b0;
      tmo_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      terr_q  <= 1'b0;
      fmap_q  <= '0;
      load_q  <= '0;
      start_q <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      add_q   <= '0;
      exp_q   <= '0;
    end else begin
      load_q  <= '0;
      start_q <= '0;
      case (state_q)
        IDLE: begin
          if (test_req && array_idle) begin
            fmap_q  <= '0;
            terr_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
            pe_q    <= '0;
            vec_q   <= '0;
            load_q  <= pe_onehot('0);
            op1_q   <= WORD_SIZE'(pat_nxt.op1);
            op2_q   <= WORD_SIZE'(pat_nxt.op2);
            add_q   <= WORD_SIZE'(pat_nxt.add);
            exp_q   <= WORD_SIZE'(pat_nxt.exp);
            state_q <= LOAD;
          end
        end
        LOAD: begin
          tmo_q   <= 1'b0;
          state_q <= START;
        end
        START: begin
          if (STW_complete[pe_q]) begin
            start_q <= pe_onehot(pe_q);
            state_q <= ARM;
          end else if (wd_expire) begin
            tmo_q   <= 1'b1;
            state_q <= EVAL;
          end
        end
        ARM: begin
          state_q <= WAIT;
        end
        WAIT: begin
          if (STW_complete[pe_q]) begin
            state_q <= EVAL;
          end else if (wd_expire) begin
            tmo_q   <= 1'b1;
            state_q <= EVAL;
          end
        end
        EVAL: begin
          if (tmo_q || !STW_result_out[pe_q]) begin
            fmap_q[pe_q] <= 1'b1;
            pass_q       <= 1'b0;
            if (tmo_q) begin
              terr_q <= 1'b1;
            end
          end else begin
            pass_q <= 1'b1;
          end
          state_q <= NEXT;
        end
        NEXT: begin
          if (more_vec) begin
            vec_q   <= vec_nxt;
            load_q  <= pe_onehot(pe_q);
            op1_q   <= WORD_SIZE'(pat_nxt.op1);
            op2_q   <= WORD_SIZE'(pat_nxt.op2);
            add_q   <= WORD_SIZE'(pat_nxt.add);
            exp_q   <= WORD_SIZE'(pat_nxt.exp);
            state_q <= LOAD;
          end else begin
            vec_q <= '0;
            if (pe_q == PE_W'(NUM_PE - 1)) begin
              state_q <= FIN;
            end else begin
              pe_q    <= pe_q + PE_W'(1);
              load_q  <= pe_onehot(pe_q + PE_W'(1));
              op1_q   <= WORD_SIZE'(pat_nxt.op1);
              op2_q   <= WORD_SIZE'(pat_nxt.op2);
              add_q   <= WORD_SIZE'(pat_nxt.add);
              exp_q   <= WORD_SIZE'(pat_nxt.exp);
              state_q <= LOAD;
            end
          end
        end
        FIN: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          op1_q   <= '0;
          op2_q   <= '0;
          add_q   <= '0;
          exp_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign timeout_err      = terr_q;
  assign fault_map        = fmap_q;
  assign STW_test_load_en = load_q;
  assign STW_start        = start_q;
  assign STW_mult_op1     = op1_q;
  assign STW_mult_op2     = op2_q;
  assign STW_add_op       = add_q;
  assign STW_expected     = exp_q;

endmodule

// File: tb/tb_stw_test_scheduler.sv
// Directed bench for stw_test_scheduler with 4 behavioural PE models.
module tb_stw_test_scheduler;

  localparam int NPE = 4;
  localparam int DLY = 1;  // PE complete returns DLY edges after it sees start (R=3)

  logic            clk, rst, test_req, array_idle;
  logic            busy, done, timeout_err;
  logic [NPE-1:0]  fault_map, load_en, start;
  logic [15:0]     op1, op2, addop, expv;
  logic [NPE-1:0]  complete, result;

  logic [NPE-1:0]  hang = '0;
  int              bad_pe = -1;
  logic            bad_vec = 1'b0;

  int errors = 0;
  int checks = 0;

  stw_test_scheduler #(
    .WORD_SIZE(16),
    .NUM_PE   (NPE),
    .TIMEOUT  (8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .test_req        (test_req),
    .array_idle      (array_idle),
    .busy            (busy),
    .done            (done),
    .timeout_err     (timeout_err),
    .fault_map       (fault_map),
    .STW_test_load_en(load_en),
    .STW_mult_op1    (op1),
    .STW_mult_op2    (op2),
    .STW_add_op      (addop),
    .STW_expected    (expv),
    .STW_start       (start),
    .STW_complete    (complete),
    .STW_result_out  (result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- PE models ----------------
  logic [NPE-1:0] pe_comp = '1;
  logic [NPE-1:0] pe_res  = '1;
  int             pe_cnt [NPE];

  function automatic logic pe_ok(input int i);
    logic [15:0] r;
    logic        broken;
    r      = op1 * op2;
    r      = r + addop;
    broken = (i == bad_pe) && (bad_vec == (op1 == 16'hFFFE));
    return (r == expv) && !broken;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < NPE; i++) begin
      if (start[i]) begin
        pe_comp[i] <= 1'b0;
        pe_cnt[i]  <= DLY;
        pe_res[i]  <= pe_ok(i);
      end else if (!pe_comp[i]) begin
        if (pe_cnt[i] <= 1) pe_comp[i] <= 1'b1;
        pe_cnt[i] <= pe_cnt[i] - 1;
      end
    end
  end

  assign complete = pe_comp & ~hang;
  assign result   = pe_res;

  // ---------------- strobe monitor ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int load_pe [256];
  int load_vec[256];
  int load_t  [256];
  int start_pe[256];
  int load_tot [NPE];
  int start_tot[NPE];
  int nload = 0, nstart = 0, viol = 0, op_bad = 0;

  function automatic int idx_of(input logic [NPE-1:0] v);
    for (int i = 0; i < NPE; i++) if (v[i]) return i;
    return 0;
  endfunction

  int   ld_idx, st_idx, ld_vec;
  logic ld_ops_ok, viol_now;
  assign ld_idx = idx_of(load_en);
  assign st_idx = idx_of(start);
  assign ld_vec = (nload > 0 && load_pe[(nload > 0) ? nload-1 : 0] == ld_idx &&
                   load_vec[(nload > 0) ? nload-1 : 0] == 0) ? 1 : 0;
  assign ld_ops_ok = (ld_vec == 1) ?
      (op1 == 16'hFFFE && op2 == 16'h0100 && addop == 16'h0010 && expv == 16'hFE10) :
      (op1 == 16'd3 && op2 == 16'd5 && addop == 16'd7 && expv == 16'd22);
  assign viol_now = ($countones(load_en) > 1) || ($countones(start) > 1) ||
                    ((|load_en) && (|start));

  initial begin
    for (int i = 0; i < NPE; i++) begin
      load_tot[i]  = 0;
      start_tot[i] = 0;
    end
  end

  always @(negedge clk) begin
    if (viol_now) viol <= viol + 1;
    if ((|load_en) && nload < 255) begin
      load_pe[nload]   <= ld_idx;
      load_vec[nload]  <= ld_vec;
      load_t[nload]    <= cyc;
      nload            <= nload + 1;
      load_tot[ld_idx] <= load_tot[ld_idx] + 1;
      if (!ld_ops_ok) op_bad <= op_bad + 1;
    end
    if ((|start) && nstart < 255) begin
      start_pe[nstart]  <= st_idx;
      nstart            <= nstart + 1;
      start_tot[st_idx] <= start_tot[st_idx] + 1;
    end
  end

  // ---------------- helpers ----------------
  int base_load[NPE];
  int base_start[NPE];
  int base_nl, base_ns;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap;
    for (int i = 0; i < NPE; i++) begin
      base_load[i]  = load_tot[i];
      base_start[i] = start_tot[i];
    end
    base_nl = nload;
    base_ns = nstart;
  endtask

  function automatic logic [15:0] seq8(input int b, input logic use_start);
    logic [15:0] s;
    s = '0;
    for (int k = 0; k < 8; k++) begin
      s = {s[13:0], use_start ? 2'(start_pe[b+k]) : 2'(load_pe[b+k])};
    end
    return s;
  endfunction

  // Pulse test_req, check acceptance, then count cycles until done.
  task automatic run_campaign(input int poke_at, output int n);
    test_req = 1'b1;
    step;
    test_req = 1'b0;
    chk("acc_busy", busy, 1);
    chk("acc_done", done, 0);
    chk("acc_fault_map", fault_map, 0);
    chk("acc_timeout_err", timeout_err, 0);
    chk("acc_load_en", load_en, 4'b0001);
    chk("acc_op1", op1, 16'd3);
    chk("acc_expected", expv, 16'd22);
    n = 0;
    while (!done && n < 200) begin
      if (n == poke_at) test_req = 1'b1;
      step;
      test_req = 1'b0;
      n++;
      if (poke_at >= 0 && n == poke_at + 1) chk("busy_after_poke", busy, 1);
    end
    chk("done_reached", done, 1);
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_done"}, done, 0);
    chk({pfx, "_fault_map"}, fault_map, 0);
    chk({pfx, "_timeout_err"}, timeout_err, 0);
    chk({pfx, "_load_en"}, load_en, 0);
    chk({pfx, "_start"}, start, 0);
    chk({pfx, "_op1"}, op1, 0);
    chk({pfx, "_op2"}, op2, 0);
    chk({pfx, "_add"}, addop, 0);
    chk({pfx, "_expected"}, expv, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    logic found;
    rst = 1'b1;
    test_req = 1'b0;
    array_idle = 1'b1;
    step;
    step;
    chk_all_zero("reset");
    rst = 1'b0;
    step;

    // A: all PEs pass; test_req mid-campaign is ignored
    snap();
    run_campaign(10, n);
    chk("A_latency", n, 57);
    chk("A_fault_map", fault_map, 4'b0000);
    chk("A_timeout_err", timeout_err, 0);
    chk("A_busy", busy, 0);
    chk("A_loads", nload - base_nl, 8);
    chk("A_starts", nstart - base_ns, 8);
    chk("A_load_order", seq8(base_nl, 1'b0), 16'h05AF);
    chk("A_start_order", seq8(base_ns, 1'b1), 16'h05AF);
    chk("A_idle_op1", op1, 0);
    chk("A_idle_expected", expv, 0);

    // Ignored request while array busy
    snap();
    array_idle = 1'b0;
    test_req = 1'b1;
    repeat (5) step;
    chk("notidle_busy", busy, 0);
    chk("notidle_done_held", done, 1);
    chk("notidle_no_loads", nload - base_nl, 0);
    test_req = 1'b0;
    array_idle = 1'b1;
    step;

    // B: PE2 fails vec1
    bad_pe = 2;
    bad_vec = 1'b1;
    snap();
    run_campaign(-1, n);
    chk("B_latency", n, 57);
    chk("B_fault_map", fault_map, 4'b0100);
    chk("B_timeout_err", timeout_err, 0);
    chk("B_pe2_starts", start_tot[2] - base_start[2], 2);
    chk("B_pe3_loads", load_tot[3] - base_load[3], 2);

    // C: PE1 never completes
    bad_pe = -1;
    hang = 4'b0010;
    snap();
    run_campaign(-1, n);
    chk("C_latency", n, 54);
    chk("C_fault_map", fault_map, 4'b0010);
    chk("C_timeout_err", timeout_err, 1);
    chk("C_pe1_starts", start_tot[1] - base_start[1], 0);
    chk("C_pe1_loads", load_tot[1] - base_load[1], 1);
    chk("C_pe3_starts", start_tot[3] - base_start[3], 2);
    chk("C_pe1_load_slot", load_pe[base_nl+2], 1);
    chk("C_pe1_span", load_t[base_nl+3] - load_t[base_nl+2], 11);

    // D: PE0 fails vec0 -> its vec1 is skipped
    hang = '0;
    bad_pe = 0;
    bad_vec = 1'b0;
    snap();
    run_campaign(-1, n);
    chk("D_latency", n, 50);
    chk("D_fault_map", fault_map, 4'b0001);
    chk("D_pe0_starts", start_tot[0] - base_start[0], 1);
    chk("D_pe0_loads", load_tot[0] - base_load[0], 1);

    // E: reset while waiting on PE2
    hang = 4'b0010;
    test_req = 1'b1;
    step;
    test_req = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      step;
      if (start[2]) found = 1'b1;
    end
    chk("E_pe2_started", found, 1);
    step;
    chk("E_pre_fault_map", fault_map, 4'b0011);
    chk("E_pre_timeout_err", timeout_err, 1);
    chk("E_pre_busy", busy, 1);
    rst = 1'b1;
    step;
    chk_all_zero("E_rst");
    rst = 1'b0;
    hang = '0;
    bad_pe = -1;
    repeat (3) step;
    snap();
    run_campaign(-1, n);
    chk("E_latency", n, 57);
    chk("E_fault_map", fault_map, 4'b0000);
    chk("E_first_pe", load_pe[base_nl], 0);

    chk("op_mismatch_count", op_bad, 0);
    chk("strobe_violations", viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
